// File: rtl/shreg_pkg.sv
// Shared types for the parametrised shift register: operation codes and FSM states.
package shreg_pkg;

    // Operation codes as presented on the op input; 10..15 are reserved no-ops.
    typedef enum logic [3:0] {
        OP_CLEAR = 4'd0,
        OP_LOAD  = 4'd1,
        OP_SRL   = 4'd2,
        OP_SLL   = 4'd3,
        OP_SRA   = 4'd4,
        OP_SRS   = 4'd5,
        OP_ROR   = 4'd6,
        OP_ROL   = 4'd7,
        OP_LFSR  = 4'd8,
        OP_SLS   = 4'd9
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // True for the multi-step operations (shifts, rotates, LFSR).
    function automatic logic is_step_op(input logic [3:0] op);
        return (op >= OP_SRL) && (op <= OP_SLS);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One single-bit step of a shift / rotate / LFSR operation (purely combinational).
module shift_step
    import shreg_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 'h1D
) (
    input  logic [WIDTH-1:0] q,
    input  logic [3:0]       op,
    input  logic             in_serial,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    // shr_body holds q moved one place right (without the new MSB),
    // shl_body holds q moved one place left (without the new LSB).
    logic [WIDTH-2:0] shr_body;
    logic [WIDTH-1:1] shl_body;
    logic             fb;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_nbr
            assign shr_body[gi]     = q[gi+1];
            assign shl_body[gi+1]   = q[gi];
        end
    endgenerate

    // Feedback is forced to 1 from the all-zero state so the LFSR cannot lock up.
    assign fb = (q == '0) ? 1'b1 : ^(q & TAPS);

    // Select the stepped value and the bit leaving the register for the current op.
    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (op)
            OP_SRL:  begin q_next = {1'b0, shr_body};     out_bit = q[0];       end
            OP_SLL:  begin q_next = {shl_body, 1'b0};     out_bit = q[WIDTH-1]; end
            OP_SRA:  begin q_next = {q[WIDTH-1], shr_body}; out_bit = q[0];     end
            OP_SRS:  begin q_next = {in_serial, shr_body}; out_bit = q[0];      end
            OP_ROR:  begin q_next = {q[0], shr_body};     out_bit = q[0];       end
            OP_ROL:  begin q_next = {shl_body, q[WIDTH-1]}; out_bit = q[WIDTH-1]; end
            OP_LFSR: begin q_next = {fb, shr_body};       out_bit = q[0];       end
            OP_SLS:  begin q_next = {shl_body, in_serial}; out_bit = q[WIDTH-1]; end
            default: begin q_next = q;                    out_bit = 1'b0;       end
        endcase
    end

endmodule

// File: rtl/param_shift_register.sv
// Multi-cycle parametrised shift register: FSM, step counter and output registers.
module param_shift_register
    import shreg_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 'h1D,
    localparam int              AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    amount,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_serial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic             serial_out
);

    state_t           state_reg, state_next;
    logic [AW-1:0]    cnt_reg,   cnt_next;
    logic [3:0]       op_reg,    op_next;
    logic [WIDTH-1:0] q_reg,     q_next;
    logic             so_reg,    so_next;
    logic             done_reg,  done_next;

    logic [WIDTH-1:0] step_q;
    logic             step_out;

    shift_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .q         (q_reg),
        .op        (op_reg),
        .in_serial (in_serial),
        .q_next    (step_q),
        .out_bit   (step_out)
    );

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            q_reg     <= '0;
            so_reg    <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            q_reg     <= q_next;
            so_reg    <= so_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic: accept requests in IDLE, perform one step per cycle in RUN.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        q_next     = q_reg;
        so_next    = so_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_CLEAR) begin
                        q_next    = '0;
                        done_next = 1'b1;
                    end else if (op == OP_LOAD) begin
                        q_next    = in_data;
                        done_next = 1'b1;
                    end else if (is_step_op(op) && (amount != '0)) begin
                        // No step on the accepting edge; stepping starts next cycle.
                        op_next    = op;
                        cnt_next   = amount;
                        state_next = ST_RUN;
                    end else begin
                        // Zero-step shift or reserved op: acknowledge only.
                        done_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                q_next   = step_q;
                so_next  = step_out;
                cnt_next = cnt_reg - AW'(1);
                if (cnt_reg == AW'(1)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state_reg == ST_RUN);
    assign done       = done_reg;
    assign q          = q_reg;
    assign serial_out = so_reg;

endmodule

// File: tb/tb_param_shift_register.sv
// Directed self-checking bench for param_shift_register (WIDTH=8, TAPS=8'h1D).
module tb_param_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op;
    logic [3:0] amount;
    logic [7:0] in_data;
    logic       in_serial;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic       serial_out;

    int checks = 0;
    int errors = 0;

    param_shift_register #(.WIDTH(8), .TAPS(8'h1D)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .amount     (amount),
        .in_data    (in_data),
        .in_serial  (in_serial),
        .busy       (busy),
        .done       (done),
        .q          (q),
        .serial_out (serial_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Called at a negedge; start is seen by the following posedge, returns at the next negedge.
    task automatic issue(input logic [3:0] o, input logic [3:0] a, input logic [7:0] d);
        op      = o;
        amount  = a;
        in_data = d;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Counts edges until done is seen (bounded), then steps past the done cycle.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] d);
        int c;
        issue(4'd1, 4'd0, d);
        wait_done(c);
    endtask

    initial begin
        int c;
        rst = 1'b1; start = 1'b0; op = '0; amount = '0; in_data = '0; in_serial = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_q",    {24'd0, q}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_so",   {31'd0, serial_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a run
        do_load(8'hFF);
        issue(4'd2, 4'd5, 8'h00);
        check("srl_busy", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        check("srl_2steps", {24'd0, q}, 32'h3F);
        #2 rst = 1'b1;
        #1;
        check("arst_q",    {24'd0, q}, 32'h00);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_so",   {31'd0, serial_out}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        // SRA by 3
        do_load(8'h96);
        issue(4'd4, 4'd3, 8'h00);
        check("sra_busy1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("sra_busy2", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("sra_busy3", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("sra_busy_end", {31'd0, busy}, 32'd0);
        check("sra_done",     {31'd0, done}, 32'd1);
        check("sra_q",        {24'd0, q}, 32'hF2);
        check("sra_so",       {31'd0, serial_out}, 32'd1);
        @(negedge clk);
        check("sra_done_clr", {31'd0, done}, 32'd0);

        // Rotate left by 9 wraps around
        do_load(8'h81);
        issue(4'd7, 4'd9, 8'h00);
        wait_done(c);
        check("rol_cycles", c, 32'd9);
        check("rol_q",      {24'd0, q}, 32'h03);
        check("rol_so",     {31'd0, serial_out}, 32'd1);

        // LFSR stepping and zero lock-up escape
        do_load(8'h01);
        check("load_keeps_so", {31'd0, serial_out}, 32'd1);
        issue(4'd8, 4'd2, 8'h00);
        @(negedge clk);
        check("lfsr_step1", {24'd0, q}, 32'h80);
        check("lfsr_so1",   {31'd0, serial_out}, 32'd1);
        wait_done(c);
        check("lfsr_step2", {24'd0, q}, 32'h40);
        issue(4'd0, 4'd0, 8'h00);
        wait_done(c);
        check("clear_q", {24'd0, q}, 32'h00);
        issue(4'd8, 4'd1, 8'h00);
        wait_done(c);
        check("lfsr_zero", {24'd0, q}, 32'h80);

        // Serial input with an ignored mid-run LOAD
        issue(4'd0, 4'd0, 8'h00);
        wait_done(c);
        issue(4'd5, 4'd4, 8'h00);
        in_serial = 1'b1;
        @(negedge clk);
        in_serial = 1'b0;
        op = 4'd1; in_data = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_serial = 1'b1;
        @(negedge clk);
        in_serial = 1'b1;
        @(negedge clk);
        in_serial = 1'b0;
        check("srs_done", {31'd0, done}, 32'd1);
        check("srs_q",    {24'd0, q}, 32'hD0);
        check("srs_so",   {31'd0, serial_out}, 32'd0);
        @(negedge clk);
        check("srs_no_queue", {24'd0, q}, 32'hD0);
        check("srs_idle",     {31'd0, busy | done}, 32'd0);

        // Zero-step and reserved ops, back-to-back in done cycles
        do_load(8'h5A);
        issue(4'd3, 4'd0, 8'h00);
        check("z_done", {31'd0, done}, 32'd1);
        check("z_busy", {31'd0, busy}, 32'd0);
        check("z_q",    {24'd0, q}, 32'h5A);
        issue(4'd12, 4'd3, 8'h00);
        check("rsv_done", {31'd0, done}, 32'd1);
        check("rsv_busy", {31'd0, busy}, 32'd0);
        check("rsv_q",    {24'd0, q}, 32'h5A);
        issue(4'd6, 4'd1, 8'h00);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        wait_done(c);
        check("b2b_cycles", c, 32'd1);
        check("ror_q", {24'd0, q}, 32'h2D);
        check("ror_so", {31'd0, serial_out}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_shift_register.md
# param_shift_register

Parametrised, multi-cycle successor to the 8-bit shift register: a WIDTH-bit register that executes load, clear, logical/arithmetic/rotate/serial shifts and an LFSR step. Each shift operation runs a programmable number of single-bit steps, one step per clock, under a start/busy/done handshake. It sits in the lab datapath wherever a shifter, serial converter or pseudo-random source is needed, and drives seven-segment or LED output logic from `q`.

## Interface
- `WIDTH`, 8: register width; minimum 2.
- `TAPS`, 8'h1D: LFSR feedback mask, WIDTH bits.
- `AW`, localparam = $clog2(WIDTH)+1: width of `amount`.
- `clk`  in  1: single clock; all state changes on posedge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request; sampled only in IDLE.
- `op`  in  4: operation code, captured with `start`.
- `amount`  in  AW: step count, captured with `start`.
- `in_data`  in  WIDTH: parallel load value.
- `in_serial`  in  1: serial input, sampled on every step edge.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle completion pulse.
- `q`  out  WIDTH: register contents.
- `serial_out`  out  1: bit shifted or rotated out on the most recent step.

## Operation
- Op codes:
  - 0 CLEAR: q←0.
  - 1 LOAD: q←in_data.
  - 2 SRL: right shift, 0 in at MSB.
  - 3 SLL: left shift, 0 in at LSB.
  - 4 SRA: right shift, MSB replicated.
  - 5 SRS: right shift, in_serial in at MSB.
  - 6 ROR: rotate right.
  - 7 ROL: rotate left.
  - 8 LFSR: fb = ^(q & TAPS), forced to 1 when q==0; q←{fb, q[WIDTH-1:1]}.
  - 9 SLS: left shift, in_serial in at LSB.
  - 10–15: reserved; behave as a zero-step no-op.
- States: IDLE and RUN.
  - IDLE + start with op 0/1: q updated at that edge; `done` pulses next cycle; stays in IDLE.
  - IDLE + start with shift/LFSR op and amount==0, or a reserved op: q unchanged; `done` pulses; stays in IDLE.
  - IDLE + start with shift/LFSR op and amount>0: latch op and amount into a counter; go to RUN; no step on this edge.
  - RUN: each edge performs one step and decrements the counter. The edge that performs the final step returns to IDLE and sets `done`.
- Steps are literal, with no modulo or clamping. A rotate by amount ≥ WIDTH wraps naturally; a logical shift by amount ≥ WIDTH yields all-zero.
- `serial_out` per step: q[0] for right shifts, right rotates and LFSR; q[WIDTH-1] for left shifts and left rotates. It holds its value between operations and is unchanged by CLEAR and LOAD.
- `start`, `op` and `amount` are ignored while busy; no queuing.
- `rst` at any time, including mid-RUN: q=0, serial_out=0, busy=0, done=0, state IDLE, counter 0.

## Timing
- Reset values: q=0, busy=0, done=0, serial_out=0.
- Start accepted at edge k with amount=N>0: busy=1 after edge k; steps occur on edges k+1..k+N; busy=0 and done=1 after edge k+N; done clears after edge k+N+1.
- Back-to-back: `start` may be asserted in the done cycle and is accepted at that edge.
- Zero-step, CLEAR and LOAD requests: done=1 in the cycle after the accepting edge; busy never rises.
- `q` and `serial_out` are registered outputs; no combinational path from inputs to outputs.

## Structure
- Package `shreg_pkg` holds the `op_t` enum (the codes above) and the `state_t` enum (IDLE, RUN).
- One combinational sub-module, `shift_step`, takes q, op, in_serial and TAPS and returns the next q and the out bit.
- The top level contains the FSM, the step counter and the registers.

## Test plan
- Reset mid-RUN: LOAD 8'hFF, start SRL with amount 5, assert rst after 2 steps → q=0, busy=0, done=0 immediately (asynchronous).
- SRA: LOAD 8'h96, start SRA with amount 3 at edge k → busy during k+1..k+3; after edge k+3 q=8'hF2, done=1 for exactly one cycle, serial_out=1.
- Rotate wrap-around: LOAD 8'h81, start ROL with amount 9 → q=8'h03, serial_out=1, total latency 10 edges.
- LFSR and zero lock-up: LOAD 8'h01, LFSR with amount 2 → q=8'h80 then 8'h40. CLEAR, then LFSR with amount 1 → q=8'h80.
- Serial input: CLEAR, SRS with amount 4, in_serial sequence 1,0,1,1 → q=8'hD0. A start pulse with op=LOAD applied mid-run is ignored.
- Zero-step and reserved ops: amount 0 with SLL, then op 12 → q unchanged, busy stays 0, done pulses once per request, and a start in the done cycle is accepted.
